// File: rtl/dmem_ctrl.sv
// Data memory controller: one request at a time, fixed-latency response,
// byte-lane stores and sign/zero-extending loads on a doubleword array.
//
// state | meaning
// IDLE  | req_ready high, waiting for a request
// BUSY  | request captured, latency counter running
// RESP  | response presented, waiting for resp_ready
module dmem_ctrl #(
  parameter int XLEN    = 64,
  parameter int DEPTH   = 512,
  parameter int LATENCY = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_read,
  input  logic [2:0]      req_write,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_rdata,
  output logic [2:0]      resp_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int NB = XLEN / 8;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

  state_e          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [XLEN-1:0] rdata_q, rdata_d;
  logic [2:0]      err_q, err_d;
  logic [XLEN-1:0] mem_q [DEPTH];

  logic [AW-1:0]   row;
  logic [2:0]      lane;
  logic [3:0]      rd_bytes, wr_bytes;
  logic            wr_code_bad, both_codes, any_access;
  logic            err_mis, err_range, err_ill;
  logic [2:0]      req_err;
  logic            accept, do_write;
  logic [XLEN-1:0] row_data, row_shift, load_val, wdata_shift;
  logic [NB-1:0]   byte_en;

  function automatic logic misaligned(input logic [3:0] nbytes, input logic [2:0] a);
    return (nbytes == 4'd2 && a[0]) ||
           (nbytes == 4'd4 && a[1:0] != 2'b00) ||
           (nbytes == 4'd8 && a != 3'b000);
  endfunction

  assign row  = req_addr[AW+2:3];
  assign lane = req_addr[2:0];

  always_comb begin
    rd_bytes = 4'd0;
    case (req_read)
      3'b001, 3'b101: rd_bytes = 4'd1;
      3'b010, 3'b110: rd_bytes = 4'd2;
      3'b011, 3'b111: rd_bytes = 4'd4;
      3'b100:         rd_bytes = 4'd8;
      default:        rd_bytes = 4'd0;
    endcase
    wr_bytes = 4'd0;
    case (req_write)
      3'b001:  wr_bytes = 4'd1;
      3'b010:  wr_bytes = 4'd2;
      3'b011:  wr_bytes = 4'd4;
      3'b100:  wr_bytes = 4'd8;
      default: wr_bytes = 4'd0;
    endcase
  end

  // Illegal store codes decode to zero bytes, so they never add a misalign flag.
  assign wr_code_bad = req_write[2] && (req_write[1:0] != 2'b00);
  assign both_codes  = (req_read != 3'b000) && (req_write != 3'b000);
  assign any_access  = (req_read != 3'b000) || (req_write != 3'b000);
  assign err_ill     = wr_code_bad || both_codes;
  assign err_range   = any_access && (req_addr[XLEN-1:AW+3] != '0);
  assign err_mis     = misaligned(rd_bytes, lane) || misaligned(wr_bytes, lane);
  assign req_err     = {err_ill, err_range, err_mis};

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

  assign accept   = req_valid && req_ready && !rst;
  assign do_write = accept && (req_err == 3'b000) && (wr_bytes != 4'd0);

  assign row_data    = mem_q[row];
  assign row_shift   = row_data >> {lane, 3'b000};
  assign wdata_shift = req_wdata << {lane, 3'b000};

  always_comb begin
    load_val = '0;
    case (req_read)
      3'b001:  load_val = {{(XLEN-8){row_shift[7]}}, row_shift[7:0]};
      3'b010:  load_val = {{(XLEN-16){row_shift[15]}}, row_shift[15:0]};
      3'b011:  load_val = {{(XLEN-32){row_shift[31]}}, row_shift[31:0]};
      3'b100:  load_val = row_data;
      3'b101:  load_val = {{(XLEN-8){1'b0}}, row_shift[7:0]};
      3'b110:  load_val = {{(XLEN-16){1'b0}}, row_shift[15:0]};
      3'b111:  load_val = {{(XLEN-32){1'b0}}, row_shift[31:0]};
      default: load_val = '0;
    endcase
  end

  always_comb begin
    byte_en = '0;
    for (int b = 0; b < NB; b++) begin
      byte_en[b] = (b >= int'(lane)) && (b < int'(lane) + int'(wr_bytes));
    end
  end

  always_ff @(posedge clk) begin
    if (do_write) begin
      for (int b = 0; b < NB; b++) begin
        if (byte_en[b]) mem_q[row][b*8 +: 8] <= wdata_shift[b*8 +: 8];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          cnt_d   = 4'(LATENCY - 1);
          state_d = (LATENCY == 1) ? RESP : BUSY;
          err_d   = req_err;
          rdata_d = (req_err == 3'b000 && rd_bytes != 4'd0) ? load_val : '0;
        end
      end
      BUSY: begin
        cnt_d = (cnt_q == 4'd0) ? 4'd0 : cnt_q - 4'd1;
        if (cnt_q <= 4'd1) state_d = RESP;
      end
      RESP: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: doc/dmem_ctrl.md
DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 SHALL have parameter XLEN, default 64, data and address width in bits.
REQ-002 SHALL have parameter DEPTH, default 512, memory size in XLEN-bit doublewords (power of two).
REQ-003 SHALL have parameter LATENCY, default 2, cycles from request acceptance to resp_valid (legal range 1..15).
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port req_valid  input  1  request present.
REQ-007 SHALL have port req_ready  output  1  controller can accept a request.
REQ-008 SHALL have port req_read  input  3  load code: 000 none, 001 LB, 010 LH, 011 LW, 100 LD, 101 LBU, 110 LHU, 111 LWU.
REQ-009 SHALL have port req_write  input  3  store code: 000 none, 001 SB, 010 SH, 011 SW, 100 SD, 101-111 illegal.
REQ-010 SHALL have port req_addr  input  XLEN  byte address.
REQ-011 SHALL have port req_wdata  input  XLEN  store data, low-order bytes used.
REQ-012 SHALL have port resp_valid  output  1  response present.
REQ-013 SHALL have port resp_ready  input  1  consumer accepts response.
REQ-014 SHALL have port resp_rdata  output  XLEN  load result, extended per code.
REQ-015 SHALL have port resp_err  output  3  bit0 misaligned, bit1 out of range, bit2 illegal code.

Function
REQ-016 SHALL use a 3-state FSM: IDLE, BUSY, RESP.
REQ-017 SHALL drive req_ready=1 only in IDLE; acceptance = req_valid && req_ready at a rising edge.
REQ-018 SHALL, on acceptance, capture request, load counter with LATENCY-1, enter BUSY (or RESP directly when LATENCY=1).
REQ-019 SHALL decrement the counter in BUSY and enter RESP when it reaches 0; resp_valid asserted exactly LATENCY cycles after the acceptance edge.
REQ-020 SHALL hold resp_valid, resp_rdata, resp_err stable in RESP until resp_valid && resp_ready, then return to IDLE (req_ready=1 the following cycle).
REQ-021 SHALL store little-endian: byte lane = addr[2:0], row = addr[log2(DEPTH)+2:3].
REQ-022 SHALL commit stores at the acceptance edge, writing only the addressed bytes; other bytes of the row unchanged.
REQ-023 SHALL read load data from the array at the acceptance edge, so a load observes all previously accepted stores.
REQ-024 SHALL sign-extend LB/LH/LW and zero-extend LBU/LHU/LWU to XLEN; LD returns the full row.
REQ-025 SHALL flag misaligned when halfword addr[0]!=0, word addr[1:0]!=0, doubleword addr[2:0]!=0.
REQ-026 SHALL flag out of range when addr[XLEN-1:3] >= DEPTH.
REQ-027 SHALL flag illegal when req_write is 101-111 or both req_read and req_write are nonzero.
REQ-028 SHALL, for any flagged request, perform no memory write, return resp_rdata=0, report all applicable err bits, with the normal latency.
REQ-029 SHALL treat req_read=req_write=000 as a no-op: resp_rdata=0, resp_err=0, normal latency.
REQ-030 SHALL ignore req_* inputs outside IDLE.

Reset
REQ-031 SHALL, when rst=1 at a rising edge, set state IDLE, counter 0, resp_valid 0, resp_rdata 0, resp_err 0; req_ready=1 the cycle after rst deasserts.
REQ-032 SHALL not accept a request on an edge where rst=1.
REQ-033 SHALL discard any pending response on reset mid-operation; a store committed before reset persists.
REQ-034 SHALL not initialise memory contents on reset.

Verification (DEPTH=512, LATENCY=2)
REQ-035 SHALL check: SD 0x0102030405060708 @0x20, then LD @0x20 -> resp_rdata 0x0102030405060708, resp_valid exactly 2 cycles after each acceptance, resp_err 0.
REQ-036 SHALL check: SD 0 @0x40, SB 0x...FF80 @0x41 -> LB @0x41 = 0xFFFFFFFFFFFFFF80, LBU @0x41 = 0x80, LD @0x40 = 0x0000000000008000.
REQ-037 SHALL check: SD 0x1111 @0x10, SW 0xDEADBEEF @0x12 -> resp_err 001; LD @0x10 = 0x1111.
REQ-038 SHALL check: LD @0x1000 -> resp_err 010, resp_rdata 0; SH @0x1001 -> resp_err 011; req_read=001 with req_write=001 -> resp_err 100.
REQ-039 SHALL check: resp_ready held 0 for 5 cycles -> resp_valid, resp_rdata, resp_err constant, req_ready 0 throughout; completes on first resp_ready=1.
REQ-040 SHALL check: rst pulsed during BUSY after SW 0xBBAA9988 @0x100 -> resp_valid 0 after reset, req_ready 1, then LW @0x100 = 0xFFFFFFFFBBAA9988.
